// File: rtl/box_filter_pkg.sv
// ---------------------------------------------------------------------------
// box_filter_pkg
// Shared widths, latency and helpers for the box-filter window stage.
//   col_w(cd, bd) : width needed for a sum of bd samples of cd bits
//   sum_w(cd, bd) : width needed for a sum of bd*bd samples of cd bits
//   LATENCY       : register stages from buff_i/dv_i to data_o/dv_o
//   pix_t         : default-width pixel sample
// ---------------------------------------------------------------------------
package box_filter_pkg;

    localparam int LATENCY   = 4;
    localparam int PIX_W_DEF = 11;

    typedef logic [PIX_W_DEF-1:0] pix_t;

    function automatic int col_w(input int cd, input int bd);
        return cd + $clog2(bd);
    endfunction

    function automatic int sum_w(input int cd, input int bd);
        return cd + $clog2(bd * bd);
    endfunction

endpackage

// File: rtl/sync_delay.sv
// ---------------------------------------------------------------------------
// sync_delay
// Fixed-depth shift register used to keep side-band signals in step with
// the filter datapath.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, clears every stage
//   i_d : WIDTH-bit input word
//   o_q : i_d delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module sync_delay #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/box_filter_window.sv
// ---------------------------------------------------------------------------
// box_filter_window
// Slides a BUF_DEPTH x BUF_DEPTH window over the pixel columns delivered by
// the line buffer and outputs the rounded window mean (box blur), 4 cycles
// after the column enters. The window is causal: data_o belongs to the
// newest column. Sync signals are delayed to match, and full_o marks outputs
// whose window contains only active pixels.
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   buff_i : BUF_DEPTH-row pixel column, index 0 = newest row
//   dv_i   : column valid
//   hs_i   : horizontal sync (active high)
//   vs_i   : vertical sync (active high)
//   data_o : filtered pixel
//   dv_o   : dv_i delayed by 4
//   hs_o   : hs_i delayed by 4
//   vs_o   : vs_i delayed by 4
//   full_o : window complete, qualifies data_o
// ---------------------------------------------------------------------------
module box_filter_window #(
    parameter int COLORDEPTH  = 11,
    parameter int SCREENWIDTH = 25,
    parameter int BUF_DEPTH   = 5,
    parameter int NORM_MUL    = 2621,
    parameter int NORM_SHIFT  = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [BUF_DEPTH-1:0][COLORDEPTH-1:0]  buff_i,
    input  logic                                  dv_i,
    input  logic                                  hs_i,
    input  logic                                  vs_i,
    output logic [COLORDEPTH-1:0]                 data_o,
    output logic                                  dv_o,
    output logic                                  hs_o,
    output logic                                  vs_o,
    output logic                                  full_o
);
    import box_filter_pkg::*;

    localparam int COL_W  = col_w(COLORDEPTH, BUF_DEPTH);
    localparam int SUM_W  = sum_w(COLORDEPTH, BUF_DEPTH);
    localparam int PROD_W = SUM_W + 17;
    localparam int CCNT_W = $clog2(SCREENWIDTH + 1);
    localparam int LCNT_W = $clog2(BUF_DEPTH);

    localparam logic [CCNT_W-1:0] COL_MAX  = CCNT_W'(BUF_DEPTH - 1);
    localparam logic [LCNT_W-1:0] LINE_MAX = LCNT_W'(BUF_DEPTH - 1);
    localparam logic [PROD_W-1:0] ROUND    = PROD_W'(1) << (NORM_SHIFT - 1);
    localparam logic [PROD_W-1:0] PIX_MAX  = PROD_W'((1 << COLORDEPTH) - 1);

    // ---------------- S1: vertical column sum ----------------
    logic [COL_W-1:0] w_colsum;
    logic [COL_W-1:0] r_colsum;
    logic             r_v1;

    always_comb begin
        w_colsum = '0;
        for (int i = 0; i < BUF_DEPTH; i++) w_colsum = w_colsum + COL_W'(buff_i[i]);
    end

    // ---------------- S2: horizontal column history ----------------
    logic [BUF_DEPTH-1:0][COL_W-1:0] r_col;

    // ---------------- S3: window sum ----------------
    logic [SUM_W-1:0] w_wsum;
    logic [SUM_W-1:0] r_wsum;

    always_comb begin
        w_wsum = '0;
        for (int i = 0; i < BUF_DEPTH; i++) w_wsum = w_wsum + SUM_W'(r_col[i]);
    end

    // ---------------- S4: normalise with rounding, clamp ----------------
    logic [PROD_W-1:0]     w_prod;
    logic [PROD_W-1:0]     w_norm;
    logic [COLORDEPTH-1:0] w_pix;
    logic [COLORDEPTH-1:0] r_data;

    always_comb begin
        w_prod = PROD_W'(r_wsum) * PROD_W'(NORM_MUL) + ROUND;
        w_norm = w_prod >> NORM_SHIFT;
        if (w_norm > PIX_MAX) w_pix = PIX_MAX[COLORDEPTH-1:0];
        else                  w_pix = w_norm[COLORDEPTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_colsum <= '0;
            r_v1     <= 1'b0;
            r_col    <= '0;
            r_wsum   <= '0;
            r_data   <= '0;
        end else begin
            r_colsum <= w_colsum;
            r_v1     <= dv_i;
            // blanking columns push zeros so they never leak into a window
            r_col[0] <= r_v1 ? r_colsum : '0;
            for (int i = 1; i < BUF_DEPTH; i++) r_col[i] <= r_col[i-1];
            r_wsum   <= w_wsum;
            r_data   <= w_pix;
        end
    end

    assign data_o = r_data;

    // ---------------- window-completeness tracking ----------------
    logic [CCNT_W-1:0] r_col_cnt;
    logic [CCNT_W-1:0] w_col_cnt_nxt;
    logic [LCNT_W-1:0] r_line_cnt;
    logic [LCNT_W-1:0] w_line_cnt_nxt;
    logic              r_dv_d;
    logic              r_vs_d;
    logic              w_line_end;
    logic              w_vs_rise;
    logic              w_full0;

    assign w_line_end = r_dv_d & ~dv_i;
    assign w_vs_rise  = vs_i & ~r_vs_d;

    always_comb begin
        w_col_cnt_nxt = '0;
        if (dv_i) w_col_cnt_nxt = (r_col_cnt == COL_MAX) ? r_col_cnt : r_col_cnt + 1'b1;

        w_line_cnt_nxt = r_line_cnt;
        if (w_vs_rise)       w_line_cnt_nxt = '0;
        else if (w_line_end) w_line_cnt_nxt = (r_line_cnt == LINE_MAX) ? r_line_cnt
                                                                          : r_line_cnt + 1'b1;
    end

    // r_col_cnt counts the valid columns already seen on this line, so
    // reaching BUF_DEPTH-1 together with a valid current column means all
    // BUF_DEPTH columns of the window are real pixels (column index >= 4).
    assign w_full0 = dv_i & (r_col_cnt == COL_MAX) & (r_line_cnt == LINE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_cnt  <= '0;
            r_line_cnt <= '0;
            r_dv_d     <= 1'b0;
            r_vs_d     <= 1'b0;
        end else begin
            r_col_cnt  <= w_col_cnt_nxt;
            r_line_cnt <= w_line_cnt_nxt;
            r_dv_d     <= dv_i;
            r_vs_d     <= vs_i;
        end
    end

    // ---------------- side-band delay ----------------
    logic [3:0] w_sync;

    sync_delay #(
        .WIDTH (4),
        .DEPTH (LATENCY)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d ({dv_i, hs_i, vs_i, w_full0}),
        .o_q (w_sync)
    );

    assign {dv_o, hs_o, vs_o, full_o} = w_sync;

endmodule

// File: tb/tb_box_filter_window.sv
module tb_box_filter_window;

    localparam int CD = 11;
    localparam int SW = 25;
    localparam int BD = 5;

    logic                   clk;
    logic                   rst;
    logic [BD-1:0][CD-1:0]  buff;
    logic                   dv, hs, vs;
    logic [CD-1:0]          data_o;
    logic                   dv_o, hs_o, vs_o, full_o;

    box_filter_window #(
        .COLORDEPTH (CD), .SCREENWIDTH (SW), .BUF_DEPTH (BD),
        .NORM_MUL (2621), .NORM_SHIFT (16)
    ) dut (
        .clk (clk), .rst (rst), .buff_i (buff), .dv_i (dv), .hs_i (hs), .vs_i (vs),
        .data_o (data_o), .dv_o (dv_o), .hs_o (hs_o), .vs_o (vs_o), .full_o (full_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int data;
        bit dv, hs, vs, full;
    } exp_t;

    exp_t ex[4];
    int   csum_h[BD];     // masked column sums, newest first
    int   run_len;        // consecutive valid columns including current
    int   lines;          // completed lines since vs rise / reset
    bit   pdv, pvs;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, first_in = -1, first_out = -1;
    int mode = 0, cval = 0, imp_hits = 0;
    bit nofull = 0, pdv_o = 0;

    function automatic int pix_mean(input int wsum);
        int r;
        r = (wsum * 2621 + 32768) >>> 16;
        return (r > 2047) ? 2047 : r;
    endfunction

    function void model_clear();
        for (int i = 0; i < BD; i++) csum_h[i] = 0;
        for (int i = 0; i < 4; i++) ex[i] = '{0, 0, 0, 0, 0};
        run_len = 0; lines = 0; pdv = 0; pvs = 0;
    endfunction

    function void model_step();
        int   s, w;
        exp_t e;
        s = 0;
        if (dv) for (int i = 0; i < BD; i++) s += int'(buff[i]);
        for (int i = BD - 1; i > 0; i--) csum_h[i] = csum_h[i-1];
        csum_h[0] = s;
        w = 0;
        for (int i = 0; i < BD; i++) w += csum_h[i];
        run_len = dv ? ((run_len < 1000) ? run_len + 1 : run_len) : 0;
        e.data = pix_mean(w);
        e.dv = dv; e.hs = hs; e.vs = vs;
        e.full = dv && (run_len >= BD) && (lines >= BD - 1);
        if (vs && !pvs)      lines = 0;
        else if (pdv && !dv) lines++;
        pdv = dv; pvs = vs;
        for (int i = 3; i > 0; i--) ex[i] = ex[i-1];
        ex[0] = e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic tick();
        if (rst && dv && first_in < 0) first_in = cyc;
        @(posedge clk);
        cyc++;
        if (rst) model_step(); else model_clear();
        @(negedge clk);
        if (dv_o && first_out < 0) first_out = cyc;
        chk("data",  32'(data_o), ex[3].data);
        chk("dv",    32'(dv_o),   32'(ex[3].dv));
        chk("hs",    32'(hs_o),   32'(ex[3].hs));
        chk("vs",    32'(vs_o),   32'(ex[3].vs));
        chk("full",  32'(full_o), 32'(ex[3].full));
        if (full_o) chk("full_implies_dv", 32'(dv_o), 1);
        if (mode == 1 && full_o) chk("const_full", 32'(data_o), cval);
        if (mode == 1 && dv_o && !pdv_o)
            chk("const_first_col", 32'(data_o), ((5 * cval) * 2621 + 32768) >>> 16);
        if (mode == 3 && data_o == 11'd82) imp_hits++;
        if (nofull) chk("no_full_after_reset", 32'(full_o), 0);
        pdv_o = dv_o;
    endtask

    task automatic drive(input bit d, input bit h, input bit v, input int c, input int l);
        dv = d; hs = h; vs = v;
        for (int i = 0; i < BD; i++) begin
            case (mode)
                1:       buff[i] = d ? CD'(cval) : '0;
                3:       buff[i] = (d && l == 6 && c == 12 && i == 2) ? 11'd2047 : 11'd0;
                default: buff[i] = CD'($urandom_range(0, 2047));
            endcase
        end
        tick();
    endtask

    task automatic frame(input int nlines, input int rst_line);
        for (int k = 0; k < 8; k++) drive(0, 0, 1, 0, 0);
        for (int k = 0; k < 2; k++) drive(0, 0, 0, 0, 0);
        nofull = 0;
        for (int l = 0; l < nlines; l++) begin
            for (int c = 0; c < SW; c++) begin
                if (l == rst_line && c == 10) begin
                    dv = 1; hs = 0; vs = 0;
                    #2 rst = 1'b0;
                    #1;
                    chk("async_rst_data", 32'(data_o), 0);
                    chk("async_rst_dv",   32'(dv_o),   0);
                    chk("async_rst_hs",   32'(hs_o),   0);
                    chk("async_rst_vs",   32'(vs_o),   0);
                    chk("async_rst_full", 32'(full_o), 0);
                    model_clear();
                    tick();
                    rst = 1'b1;
                    nofull = 1;
                end else begin
                    drive(1, 0, 0, c, l);
                end
            end
            for (int b = 0; b < 6; b++) drive(0, (b == 1 || b == 2), 0, 0, l);
        end
    endtask

    initial begin
        dv = 0; hs = 0; vs = 0; buff = '0;
        model_clear();
        rst = 1'b1;
        #1 rst = 1'b0;

        // reset held with random inputs; outputs must stay zero
        mode = 0;
        for (int k = 0; k < 6; k++) begin
            dv = 1'($urandom); hs = 1'($urandom); vs = 1'($urandom);
            for (int i = 0; i < BD; i++) buff[i] = CD'($urandom_range(0, 2047));
            tick();
        end
        rst = 1'b1;
        dv = 0; hs = 0; vs = 0;
        tick();

        // constant field, six frames
        mode = 1; cval = 100;
        for (int f = 0; f < 6; f++) frame(6, -1);
        chk("first_dv_latency", 32'(first_out - first_in), 4);

        // saturation
        cval = 2047;
        frame(6, -1);

        // single-column impulse on line 6
        mode = 3; imp_hits = 0;
        frame(8, -1);
        chk("impulse_hits", imp_hits, 5);

        // PRBS data with line-buffer timing, then a mid-line reset
        mode = 2;
        frame(7, -1);
        frame(7, -1);
        frame(7, 5);
        frame(6, -1);
        nofull = 0;
        for (int k = 0; k < 6; k++) drive(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
